// File: rtl/mdu.sv
// mdu: multiply/divide unit for the execute stage. It owns the architectural
// HI/LO registers. A mult/multu/div/divu is computed from the operands
// sampled at the start edge and held in a pending register. HI/LO are
// updated only when the fixed-latency busy window ends, which matches the
// timing of a real iterative multiplier or divider.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low; clears all state immediately
//   MDOp   0/7 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   A, B   rs/rt operands (forwarded values)
//   Start  combinational: MDOp is one of mult/multu/div/divu
//   Busy   registered; high while an operation is in flight
//   HI, LO architectural HI/LO registers
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    phi_q, phi_d, plo_q, plo_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           nocommit_q, nocommit_d;  // divide by zero: leave HI/LO alone

  // Arithmetic datapath, evaluated only at the start edge.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] amag, bmag, bsafe, qmag, rmag, quo, rem;

  assign Start = (MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
                 (MDOp == OP_DIV)  || (MDOp == OP_DIVU);

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed division is done on magnitudes, then the signs are reapplied.
  // This makes 0x80000000 / -1 fall out naturally as 0x80000000 rem 0.
  assign a_neg = (MDOp == OP_DIV) && A[31];
  assign b_neg = (MDOp == OP_DIV) && B[31];
  assign amag  = a_neg ? (~A + 32'd1) : A;
  assign bmag  = b_neg ? (~B + 32'd1) : B;
  assign bsafe = (bmag == 32'd0) ? 32'd1 : bmag;
  assign qmag  = amag / bsafe;
  assign rmag  = amag % bsafe;
  assign quo   = (a_neg ^ b_neg) ? (~qmag + 32'd1) : qmag;
  assign rem   = a_neg ? (~rmag + 32'd1) : rmag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phi_q      <= '0;
      plo_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      nocommit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phi_q      <= phi_d;
      plo_q      <= plo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      nocommit_q <= nocommit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phi_d      = phi_q;
    plo_d      = plo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    nocommit_d = nocommit_q;
    unique case (state_q)
      IDLE: begin
        unique case (MDOp)
          OP_MULT: begin
            {phi_d, plo_d} = prod_s;
            nocommit_d     = 1'b0;
            cnt_d          = CW'(MULT_CYCLES);
          end
          OP_MULTU: begin
            {phi_d, plo_d} = prod_u;
            nocommit_d     = 1'b0;
            cnt_d          = CW'(MULT_CYCLES);
          end
          OP_DIV, OP_DIVU: begin
            phi_d      = rem;
            plo_d      = quo;
            nocommit_d = (B == 32'd0);
            cnt_d      = CW'(DIV_CYCLES);
          end
          OP_MTHI: hi_d = A;
          OP_MTLO: lo_d = A;
          default: ;
        endcase
        if (Start) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Any MDOp while running is ignored; the hazard unit prevents it.
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (!nocommit_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit instantiated beside the ALU in the execute stage. Accepts mult/multu/div/divu/mthi/mtlo from the E-stage control word, runs a multi-cycle operation, and owns the architectural HI/LO registers. HI/LO are read by mfhi/mflo and carried to the memory stage on the same path as the ALU result. Busy and the start strobe feed the hazard unit, which stalls D when an md-class instruction would collide.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (≥1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
- A  input  32  rs operand (forwarded value)
- B  input  32  rt operand (forwarded value)
- Start  output  1  combinational: MDOp ∈ {1..4}
- Busy  output  1  registered; high while an operation is in flight
- HI  output  32  registered HI
- LO  output  32  registered LO

## Operation
- State: IDLE, RUN. Down-counter cnt (4 bits sufficient for defaults; size to max parameter). Pending result regs phi/plo.
- IDLE, MDOp 1–4 at edge: compute result from A/B; load phi/plo; load cnt = MULT_CYCLES or DIV_CYCLES; enter RUN; Busy=1.
- IDLE, MDOp 5 (mthi): HI ← A at edge. MDOp 6 (mtlo): LO ← A. Busy stays 0.
- RUN: cnt decrements each edge; on the edge where cnt reaches 0 (i.e., cnt==1 before the edge), HI←phi, LO←plo, Busy←0, back to IDLE.
- RUN, any nonzero MDOp: ignored (no restart, no mthi/mtlo). The hazard unit guarantees that this does not occur; the verification bench checks that it is ignored.
- Arithmetic:
  - mult: signed 32×32 → 64; HI=[63:32], LO=[31:0].
  - multu: unsigned likewise.
  - div: LO=quotient truncated toward zero, HI=remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - B==0 for div/divu: Busy sequence runs normally; HI/LO are left unchanged at completion.
- Operands are sampled only at the start edge; later changes to A/B have no effect.

## Timing
- Reset (async, low): Busy=0, HI=0, LO=0, cnt=0, state IDLE. This holds mid-operation; the pending result is discarded.
- Start edge T0. Busy=1 from after T0 through T0+N−1. At T0+N, Busy=0 and HI/LO are updated at the same edge (N = MULT_CYCLES or DIV_CYCLES).
- mfhi/mflo issued in E at the cycle after Busy falls reads the new value.
- Back-to-back: a new start is accepted on the edge after Busy falls. It cannot be accepted on the falling edge itself.
- mthi/mtlo: single-cycle, visible after the edge.
- Start is purely combinational from MDOp. The hazard unit stalls on Start|Busy for md-class instructions in D.

## Test plan
- Reset: hold reset=0 two cycles, then release → HI=0, LO=0, Busy=0. Assert reset during RUN at cnt=3 → Busy=0 and HI=LO=0 immediately, with no later commit.
- mult A=0xFFFFFFFE(−2), B=3 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=−7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo; divu B=0 → Busy high 10 cycles, then HI=0x11, LO=0x22.
- Operand stability and ignored ops: start mult 4×5, change A/B and drive MDOp=5 and MDOp=1 during RUN → final LO=20, HI=0, Busy low after exactly 5 cycles.
- Back-to-back: mult then div issued the cycle after Busy falls → the second op is accepted, Busy is high 10 more cycles, and HI/LO first show the mult result, then the div result.
